// File: rtl/ss_scan_decoder.sv
// Display-side receiver for a multiplexed four-digit seven-segment scan.
// Settles each anode dwell, decodes the digit and emits whole frames as BCD and binary.
module ss_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetButton,
    input  logic [7:0]  ss,
    input  logic [3:0]  enables,
    output logic [15:0] digits,
    output logic [13:0] value,
    output logic        negative,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        frame_err,
    output logic        scan_lost
);

    localparam logic [3:0]    SETTLE_C  = 4'(SETTLE);
    localparam int unsigned   IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } state_t;

    state_t        state_q;
    logic [6:0]    s_q, s_prev_q;
    logic [3:0]    e_q, e_prev_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   slots_q, slots_d;
    logic [3:0]    mask_q, mask_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          lost_q, lost_d;
    logic [15:0]   digits_q;
    logic [13:0]   value_q, value_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;
    logic          fv_q, fc_q;

    logic          valid, same, capture, emit;
    logic [1:0]    pos;
    logic [3:0]    code;

    logic unused_dp;
    assign unused_dp = ss[7];

    function automatic logic [3:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h40:   return 4'h0;
            7'h79:   return 4'h1;
            7'h24:   return 4'h2;
            7'h30:   return 4'h3;
            7'h19:   return 4'h4;
            7'h12:   return 4'h5;
            7'h02:   return 4'h6;
            7'h78:   return 4'h7;
            7'h00:   return 4'h8;
            7'h10:   return 4'h9;
            7'h7F:   return 4'hA;
            7'h3F:   return 4'hB;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [13:0] num(input logic [3:0] d);
        return (d <= 4'd9) ? {10'd0, d} : '0;
    endfunction

    always_comb begin
        valid = 1'b1;
        pos   = 2'd0;
        case (e_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: valid = 1'b0;
        endcase
        same = (s_q == s_prev_q) && (e_q == e_prev_q);
        code = seg_decode(s_q);

        // Count saturates at SETTLE; HELD blocks a second capture in the same dwell.
        if (!valid)
            cnt_d = '0;
        else if (!same)
            cnt_d = 4'd1;
        else if (cnt_q == SETTLE_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 4'd1;
        capture = valid && (state_q != ST_HELD) && (cnt_d == SETTLE_C);
    end

    always_comb begin
        emit    = (mask_q == 4'hF);
        slots_d = slots_q;
        // Emit and loss both start an empty frame; a coincident capture joins the new one.
        mask_d  = (emit || lost_q) ? '0 : mask_q;
        if (capture) begin
            slots_d[{pos, 2'b00} +: 4] = code;
            mask_d[pos]                = 1'b1;
        end

        if (capture)
            idle_d = '0;
        else if (idle_q == TIMEOUT_C)
            idle_d = idle_q;
        else
            idle_d = idle_q + IW'(1);

        if (capture)
            lost_d = 1'b0;
        else if (idle_d == TIMEOUT_C)
            lost_d = 1'b1;
        else
            lost_d = lost_q;
    end

    always_comb begin
        neg_d = 1'b0;
        err_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            neg_d = neg_d | (slots_q[4*i +: 4] == 4'hB);
            err_d = err_d | (slots_q[4*i +: 4] == 4'hF);
        end
        value_d = num(slots_q[15:12]) * 14'd1000
                + num(slots_q[11:8])  * 14'd100
                + num(slots_q[7:4])   * 14'd10
                + num(slots_q[3:0]);
    end

    always_ff @(posedge clk or negedge resetButton) begin
        if (!resetButton) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            s_prev_q <= '0;
            e_q      <= '1;
            e_prev_q <= '1;
            cnt_q    <= '0;
            slots_q  <= '0;
            mask_q   <= '0;
            idle_q   <= '0;
            lost_q   <= 1'b0;
            digits_q <= '0;
            value_q  <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            fv_q     <= 1'b0;
            fc_q     <= 1'b0;
        end else begin
            s_q      <= ss[6:0];
            e_q      <= enables;
            s_prev_q <= s_q;
            e_prev_q <= e_q;
            cnt_q    <= cnt_d;

            case (state_q)
                ST_IDLE:   state_q <= valid ? ST_SETTLE : ST_IDLE;
                ST_SETTLE: begin
                    if (!valid)
                        state_q <= ST_IDLE;
                    else if (capture)
                        state_q <= ST_HELD;
                    else
                        state_q <= ST_SETTLE;
                end
                ST_HELD: begin
                    if (!valid)
                        state_q <= ST_IDLE;
                    else if (!same)
                        state_q <= ST_SETTLE;
                    else
                        state_q <= ST_HELD;
                end
                default:   state_q <= ST_IDLE;
            endcase

            slots_q <= slots_d;
            mask_q  <= mask_d;
            idle_q  <= idle_d;
            lost_q  <= lost_d;
            fv_q    <= emit;
            fc_q    <= emit && (slots_q != digits_q);
            if (emit) begin
                digits_q <= slots_q;
                value_q  <= value_d;
                neg_q    <= neg_d;
                err_q    <= err_d;
            end
        end
    end

    assign digits        = digits_q;
    assign value         = value_q;
    assign negative      = neg_q;
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;
    assign frame_err     = err_q;
    assign scan_lost     = lost_q;

endmodule
